wb_sram_slave: RTL and testbench

//  Wishbone classic-cycle responder (slave) backed by a word-addressed synchronous RAM.
//  It answers the bus master of the min SOPC (CPU data/instruction port, or a bench initiator).

---
 rtl/wb_sram_slave.sv | 140 ++++++++++++++
 tb/tb_wb_sram_slave.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_slave.sv
// Wishbone classic-cycle slave backed by a word-addressed synchronous RAM.
// Each accepted request waits WAIT_STATES cycles, then ends with a one-cycle ACK or ERR pulse.
module wb_sram_slave #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    // S_RESP is the commit cycle; its result is registered, so ack/err show in the following cycle.
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdat_q, rdat_d;

    logic [31:0]           mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  hit;
    logic                  wr_en;
    logic [3:0]            lane_we;

    // BASE_ADDR is aligned to the RAM size, so the range test reduces to comparing upper bits.
    assign word_idx = adr_q[ADDR_WIDTH+1:2];
    assign hit      = (adr_q[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]) && (adr_q[1:0] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            wdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rdat_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            wdat_q     <= wdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            rdat_q     <= rdat_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        unique case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d      = wb_adr_i;
                    we_d       = wb_we_i;
                    sel_d      = wb_sel_i;
                    wdat_d     = wb_dat_i;
                    wait_cnt_d = WAIT_INIT;
                    state_d    = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = S_IDLE;
                end else if (wait_cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        rdat_d = rdat_q;
        wr_en  = 1'b0;
        if (state_q == S_RESP) begin
            if (hit) begin
                ack_d = 1'b1;
                wr_en = we_q;
                if (!we_q) begin
                    rdat_d = mem[word_idx];
                end
            end else begin
                err_d  = 1'b1;
                rdat_d = '0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_we[gi] = wr_en & sel_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (lane_we[b]) begin
                mem[word_idx][8*b +: 8] <= wdat_q[8*b +: 8];
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Directed bench for wb_sram_slave: one instance with two wait states, one with none,
// both driven from the same bus signals.
module tb_wb_sram_slave;

    logic        clk;
    logic        rst;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_i;
    logic [3:0]  sel;
    logic [31:0] dat_o, dat0_o;
    logic        ack, err, ack0, err0;

    int total = 0;
    int bad   = 0;

    wb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat_i),
        .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_err_o(err)
    );

    wb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
        .clk(clk), .rst(rst),
        .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
        .wb_sel_i(sel), .wb_dat_i(dat_i),
        .wb_dat_o(dat0_o), .wb_ack_o(ack0), .wb_err_o(err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // One bus transaction on the WAIT_STATES=2 instance; n = edges from request edge to ack/err (-1 on timeout).
    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output int n, output logic got_ack, output logic got_err,
                        output logic [31:0] rd, output logic pulse_ok);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
        n = -1; got_ack = 1'b0; got_err = 1'b0; rd = '0; pulse_ok = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack || err) begin
                n = i - 1; got_ack = ack; got_err = err; rd = dat_o;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        pulse_ok = !ack && !err;
        $display("xfer we=%b adr=%h sel=%b wdat=%h -> edges=%0d ack=%b err=%b rdat=%h",
                 w, a, s, d, n, got_ack, got_err, rd);
    endtask

    task automatic test_reset();
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
        #2 rst = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            total++;
            if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) begin
                bad++;
                $display("FAIL reset_hold cyc%0d: ack=%b err=%b dat=%h, want 0 0 00000000", i, ack, err, dat_o);
            end
            cyc = 1'($urandom_range(0, 1)); stb = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
            adr = $urandom(); sel = 4'($urandom()); dat_i = $urandom();
        end
        #7;
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (ack !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL idle_after_reset cyc%0d: ack=%b err=%b, want 0 0", i, ack, err);
            end
        end
    endtask

    task automatic test_write_read();
        int n; logic ga, ge, po; logic [31:0] rd;
        xfer(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, n, ga, ge, rd, po);
        total++;
        if (n !== 3 || ga !== 1'b1 || ge !== 1'b0) begin
            bad++; $display("FAIL wr_latency: edges=%0d ack=%b err=%b, want 3 1 0", n, ga, ge);
        end
        total++;
        if (po !== 1'b1) begin bad++; $display("FAIL wr_pulse: ack still high next cycle=%b, want single pulse", !po); end
        xfer(1'b0, 32'h10, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (n !== 3 || ga !== 1'b1 || rd !== 32'hDEADBEEF) begin
            bad++; $display("FAIL rd_deadbeef: edges=%0d ack=%b dat=%h, want 3 1 deadbeef", n, ga, rd);
        end
        total++;
        if (po !== 1'b1) begin bad++; $display("FAIL rd_pulse: ack still high next cycle=%b, want single pulse", !po); end
    endtask

    task automatic test_byte_lanes();
        int n; logic ga, ge, po; logic [31:0] rd;
        xfer(1'b1, 32'h10, 4'b0010, 32'h0000_5500, n, ga, ge, rd, po);
        xfer(1'b0, 32'h10, 4'h0, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b1 || rd !== 32'hDEAD55EF) begin
            bad++; $display("FAIL lane1_write: ack=%b dat=%h, want 1 dead55ef", ga, rd);
        end
        xfer(1'b1, 32'h10, 4'h0, 32'hFFFF_FFFF, n, ga, ge, rd, po);
        total++;
        if (n !== 3 || ga !== 1'b1 || ge !== 1'b0) begin
            bad++; $display("FAIL sel0_ack: edges=%0d ack=%b err=%b, want 3 1 0", n, ga, ge);
        end
        xfer(1'b0, 32'h10, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b1 || rd !== 32'hDEAD55EF) begin
            bad++; $display("FAIL sel0_unchanged: ack=%b dat=%h, want 1 dead55ef", ga, rd);
        end
    endtask

    task automatic test_errors();
        int n; logic ga, ge, po; logic [31:0] rd;
        xfer(1'b0, 32'h0000_1000, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (n !== 3 || ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0) begin
            bad++; $display("FAIL err_range: edges=%0d ack=%b err=%b dat=%h, want 3 0 1 00000000", n, ga, ge, rd);
        end
        xfer(1'b0, 32'h12, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b0 || ge !== 1'b1 || rd !== 32'h0 || po !== 1'b1) begin
            bad++; $display("FAIL err_misaligned: ack=%b err=%b dat=%h pulse_ok=%b, want 0 1 00000000 1", ga, ge, rd, po);
        end
        xfer(1'b1, 32'h0000_1010, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b0 || ge !== 1'b1) begin
            bad++; $display("FAIL err_range_write: ack=%b err=%b, want 0 1", ga, ge);
        end
        xfer(1'b0, 32'h10, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b1 || rd !== 32'hDEAD55EF) begin
            bad++; $display("FAIL after_err_read: ack=%b dat=%h, want 1 dead55ef", ga, rd);
        end
        xfer(1'b1, 32'h0000_0FFC, 4'hF, 32'hCAFE_F00D, n, ga, ge, rd, po);
        xfer(1'b0, 32'h0000_0FFC, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b1 || ge !== 1'b0 || rd !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL top_word: ack=%b err=%b dat=%h, want 1 0 cafef00d", ga, ge, rd);
        end
    endtask

    task automatic test_abort();
        int n; logic ga, ge, po; logic [31:0] rd; logic seen;
        xfer(1'b1, 32'h20, 4'hF, 32'hAAAA_0000, n, ga, ge, rd, po);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'h1234_5678;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin @(negedge clk); if (ack || err) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_resp: ack/err seen=%b, want 0", seen); end
        xfer(1'b0, 32'h20, 4'hF, 32'h0, n, ga, ge, rd, po);
        total++;
        if (ga !== 1'b1 || rd !== 32'hAAAA_0000) begin
            bad++; $display("FAIL abort_nowrite: ack=%b dat=%h, want 1 aaaa0000", ga, rd);
        end
        // k=2 resets during the last wait cycle, k=3 during the commit cycle
        for (int k = 2; k <= 3; k++) begin
            @(negedge clk);
            cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat_i = 32'h1234_5678;
            for (int j = 0; j < k; j++) @(negedge clk);
            rst = 1'b1; cyc = 1'b0; stb = 1'b0;
            #1;
            total++;
            if (ack !== 1'b0 || err !== 1'b0 || dat_o !== 32'h0) begin
                bad++; $display("FAIL rst_async depth%0d: ack=%b err=%b dat=%h, want 0 0 00000000", k, ack, err, dat_o);
            end
            #2 rst = 1'b0;
            seen = 1'b0;
            for (int i = 0; i < 6; i++) begin @(negedge clk); if (ack || err) seen = 1'b1; end
            total++;
            if (seen !== 1'b0) begin bad++; $display("FAIL rst_resp depth%0d: ack/err seen=%b, want 0", k, seen); end
            xfer(1'b0, 32'h20, 4'hF, 32'h0, n, ga, ge, rd, po);
            total++;
            if (ga !== 1'b1 || rd !== 32'hAAAA_0000) begin
                bad++; $display("FAIL rst_nowrite depth%0d: ack=%b dat=%h, want 1 aaaa0000", k, ga, rd);
            end
        end
    endtask

    task automatic test_back_to_back(input logic ws0);
        int k; int last; int spacing; int first_at;
        logic a; logic [31:0] d; logic [31:0] exp;
        spacing  = ws0 ? 2 : 4;
        first_at = ws0 ? 2 : 4;
        k = 0; last = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h0; sel = 4'hF; dat_i = 32'h0;
        for (int c = 1; c <= 60 && k < 4; c++) begin
            @(negedge clk);
            a = ws0 ? ack0 : ack;
            d = ws0 ? dat0_o : dat_o;
            if (a) begin
                exp = 32'hC0DE_0000 + 32'(k) * 32'h0101;
                total++;
                if (d !== exp) begin
                    bad++; $display("FAIL b2b_data ws0=%b read%0d: dat=%h, want %h", ws0, k, d, exp);
                end
                total++;
                if ((k == 0 && c !== first_at) || (k > 0 && c - last !== spacing)) begin
                    bad++; $display("FAIL b2b_timing ws0=%b read%0d: at cycle %0d prev %0d, want first %0d spacing %0d",
                                    ws0, k, c, last, first_at, spacing);
                end
                $display("b2b ws0=%b read%0d adr=%h dat=%h cycle=%0d", ws0, k, adr, d, c);
                last = c;
                k++;
                if (k < 4) adr = 32'(4 * k);
                else begin cyc = 1'b0; stb = 1'b0; end
            end
        end
        cyc = 1'b0; stb = 1'b0;
        total++;
        if (k !== 4) begin bad++; $display("FAIL b2b_count ws0=%b: acks=%0d, want 4", ws0, k); end
        repeat (6) @(negedge clk);
    endtask

    initial begin
        int n; logic ga, ge, po; logic [31:0] rd;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_abort();
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, 32'(4 * i), 4'hF, 32'hC0DE_0000 + 32'(i) * 32'h0101, n, ga, ge, rd, po);
        end
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
